// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the in-order pipeline, sitting in ID between decode and the operand muxes.
// Latency: fwd_sel_o and stall_o are combinational from the registered entries and the current inputs.
//   Entries shift on every rising clk_i edge.
// Backpressure: stall_o holds fetch/ID and puts a bubble into EX. Upstream keeps issue_* stable until the stall releases.
// Ports:
//   clk_i, rst_n_i              clock; asynchronous active-low reset
//   issue_valid_i/regwrite_i/   issuing instruction: valid, writes a register, is a load,
//   is_load_i/rd_i/rs_i           destination, and packed source operands
//   flush_i                     kill the issuing instruction (bubble into EX, no stall)
//   stall_o                     load-use hazard stall
//   fwd_sel_o                   per operand: 0 = register file, k = result of entry k-1
//   stall_cnt_o                 saturating count of stall cycles
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_regwrite_i,
  input  logic                      issue_is_load_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] issue_rs_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } entry_t;

  // ent[0] = EX, ent[1] = MEM, ... ; a larger index is an older instruction
  entry_t [DEPTH-1:0] ent;

  logic              hazard;
  logic              found;
  logic [REG_AW-1:0] src;

  // Scan from the youngest entry, so the first match is the freshest producer.
  // Only the winning entry decides the hazard. An older load shadowed by a
  // younger ALU write to the same register does not stall.
  always_comb begin
    hazard    = 1'b0;
    found     = 1'b0;
    src       = '0;
    fwd_sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      src   = issue_rs_i[j*REG_AW +: REG_AW];
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && (src != '0) && ent[k].valid && ent[k].regwrite &&
            (ent[k].rd != '0) && (ent[k].rd == src)) begin
          found                      = 1'b1;
          fwd_sel_o[j*SELW +: SELW]  = SELW'(k + 1);
          if (ent[k].is_load && (k < LOAD_READY)) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o = issue_valid_i & ~flush_i & hazard;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ent <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent[k] <= ent[k-1];
      end
      if (issue_valid_i && !stall_o && !flush_i) begin
        ent[0] <= '{valid: 1'b1, regwrite: issue_regwrite_i,
                    is_load: issue_is_load_i, rd: issue_rd_i};
      end else begin
        ent[0] <= '0;
      end
    end
  end

  // The count holds at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Two instances are used: defaults (a), and a deep one with CNT_W=2 (b).
// Latency: outputs are sampled mid-cycle, after the inputs settle.
// Backpressure: stimulus holds issue_* stable while the model predicts a stall.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv[2], irw[2], ild[2], fl[2];
  logic [4:0] ird[2];
  logic [9:0] irs[2];

  logic        st_a, st_b;
  logic [3:0]  sel_a;
  logic [7:0]  sel_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .NUM_SRC(2), .LOAD_READY(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(iv[0]), .issue_regwrite_i(irw[0]),
    .issue_is_load_i(ild[0]), .issue_rd_i(ird[0]), .issue_rs_i(irs[0]), .flush_i(fl[0]),
    .stall_o(st_a), .fwd_sel_o(sel_a), .stall_cnt_o(cnt_a));

  hazard_scoreboard #(.REG_AW(5), .DEPTH(8), .NUM_SRC(2), .LOAD_READY(6), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(iv[1]), .issue_regwrite_i(irw[1]),
    .issue_is_load_i(ild[1]), .issue_rd_i(ird[1]), .issue_rs_i(irs[1]), .flush_i(fl[1]),
    .stall_o(st_b), .fwd_sel_o(sel_b), .stall_cnt_o(cnt_b));

  // Reference model: a list of recorded instructions, indexed by age in cycles.
  typedef struct {
    bit       v;
    bit       rw;
    bit       ld;
    bit [4:0] rd;
  } rec_t;

  typedef struct {
    bit        stall;
    bit [15:0] sel;
    bit [15:0] cnt;
  } exp_t;

  rec_t hist[2][8];
  int   dep[2]  = '{3, 8};
  int   lr[2]   = '{1, 6};
  int   selw[2] = '{2, 4};
  int   cmax[2] = '{65535, 3};
  int   ecnt[2];

  exp_t qa[$];
  exp_t qb[$];
  event obs;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void predict(int d, output bit st, output bit [15:0] sel);
    bit hz;
    hz  = 1'b0;
    sel = '0;
    for (int j = 0; j < 2; j++) begin
      bit [4:0] s;
      s = irs[d][j*5 +: 5];
      if (s != 0) begin
        for (int k = 0; k < dep[d]; k++) begin
          if (hist[d][k].v && hist[d][k].rw && hist[d][k].rd != 0 && hist[d][k].rd == s) begin
            sel = sel | (16'(k + 1) << (j * selw[d]));
            if (hist[d][k].ld && k < lr[d]) hz = 1'b1;
            break;
          end
        end
      end
    end
    st = iv[d] && !fl[d] && hz;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0;
      for (int k = 0; k < 8; k++) hist[d][k] = '{v: 1'b0, rw: 1'b0, ld: 1'b0, rd: 5'd0};
    end
  endtask

  task automatic commit();
    bit        st;
    bit [15:0] sel;
    for (int d = 0; d < 2; d++) begin
      predict(d, st, sel);
      if (st && ecnt[d] < cmax[d]) ecnt[d]++;
      for (int k = dep[d] - 1; k >= 1; k--) hist[d][k] = hist[d][k-1];
      if (iv[d] && !st && !fl[d])
        hist[d][0] = '{v: 1'b1, rw: irw[d], ld: ild[d], rd: ird[d]};
      else
        hist[d][0] = '{v: 1'b0, rw: 1'b0, ld: 1'b0, rd: 5'd0};
    end
  endtask

  task automatic push_exp();
    exp_t e;
    bit   st;
    bit [15:0] sel;
    for (int d = 0; d < 2; d++) begin
      predict(d, st, sel);
      e.stall = st;
      e.sel   = sel;
      e.cnt   = 16'(ecnt[d]);
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  // One clock cycle: apply the edge to the model, drive dut d, and idle the other dut.
  task automatic cyc(int d, bit v, bit rw, bit ld, bit [4:0] rd, bit [4:0] rs0, bit [4:0] rs1, bit f);
    @(posedge clk);
    if (rst_n) commit();
    #1;
    iv[d] = v; irw[d] = rw; ild[d] = ld; ird[d] = rd; irs[d] = {rs1, rs0}; fl[d] = f;
    iv[1-d] = 0; irw[1-d] = 0; ild[1-d] = 0; ird[1-d] = 0; irs[1-d] = 0; fl[1-d] = 0;
    push_exp();
    #2 ->obs;
  endtask

  // Reset asserted mid-cycle, with the inputs left as they are; the outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    push_exp();
    #2 ->obs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(int d);
    exp_t      e;
    bit        st;
    bit [15:0] sel, cnt;
    n_vec++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      n_err++;
      $display("FAIL dut%0d queue: no expected entry at t=%0t", d, $time);
      return;
    end
    e   = (d == 0) ? qa.pop_front() : qb.pop_front();
    st  = (d == 0) ? st_a : st_b;
    sel = (d == 0) ? 16'(sel_a) : 16'(sel_b);
    cnt = (d == 0) ? cnt_a : 16'(cnt_b);
    if (st !== e.stall || cnt !== e.cnt || (!e.stall && sel !== e.sel)) begin
      n_err++;
      $display("FAIL dut%0d t=%0t stall/sel/cnt: got %0b/%h/%0d want %0b/%h/%0d",
               d, $time, st, sel, cnt, e.stall, e.sel, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(obs);
      check(0);
      check(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    bit        st;
    bit [15:0] sel;
    bit        v, rw, ld, f;
    bit [4:0]  rd, r0, r1;

    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; irw[d] = 0; ild[d] = 0; fl[d] = 0; ird[d] = 0; irs[d] = 0;
    end
    clear_model();
    #2;
    push_exp();
    #1 ->obs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU producer r3, consumers at distance 1, 2 and 4
    cyc(0, 1, 1, 0, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 3, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 3, 3, 0);

    // Load-use: one stall cycle, then forwarding from MEM
    cyc(0, 1, 1, 1, 5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 5, 0, 0);
    cyc(0, 1, 0, 0, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Youngest writer wins
    cyc(0, 1, 1, 0, 7, 0, 0, 0);
    cyc(0, 1, 1, 0, 7, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 7, 7, 0);

    // r0 writer never forwards; flushed consumer of a load neither stalls nor records
    cyc(0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 9, 0, 0, 0);
    cyc(0, 1, 1, 0, 9, 9, 0, 1);
    cyc(0, 1, 0, 0, 0, 9, 0, 0);

    // Reset in the middle of a stall
    cyc(0, 1, 1, 1, 5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 5, 0, 0);
    do_reset();
    cyc(0, 1, 0, 0, 0, 5, 5, 0);

    // Random traffic on the default instance
    st = 0;
    v = 0; rw = 0; ld = 0; f = 0; rd = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        v  = ($urandom_range(0, 7) != 0);
        rw = ($urandom_range(0, 3) != 0);
        ld = ($urandom_range(0, 2) == 0);
        rd = 5'($urandom_range(0, 7));
        r0 = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
      end
      f = ($urandom_range(0, 9) == 0);
      cyc(0, v, rw, ld, rd, r0, r1, f);
      predict(0, st, sel);
    end

    // Deep instance: a six-cycle load-use stall saturates the 2-bit counter at 3
    cyc(1, 1, 1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 5, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    #10;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expected entries left unchecked", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the in-order pipeline. It supersedes the fixed two-stage forwarding comparator with a shift-register scoreboard. The scoreboard tracks the destination of every instruction in flight over `DEPTH` stages past issue. For each of `NUM_SRC` source operands of the issuing instruction, it produces a forwarding select. It also detects load-use hazards, raises a stall, inserts a bubble and keeps a saturating stall-cycle counter. It sits in the ID stage, between decode and the operand muxes.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `DEPTH`, 3: tracked stages past issue; entry 0 = EX, entry 1 = MEM, entry 2 = WB.
- `NUM_SRC`, 2: source operands per instruction.
- `LOAD_READY`, 1: lowest entry index at which load data is forwardable; 1 ≤ `LOAD_READY` < `DEPTH`.
- `CNT_W`, 16: stall counter width.
- Derived: `SELW` = $clog2(`DEPTH`+1).

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `issue_valid_i`, in, 1: the instruction in ID is valid.
- `issue_regwrite_i`, in, 1: the issuing instruction writes a register.
- `issue_is_load_i`, in, 1: the issuing instruction is a load.
- `issue_rd_i`, in, `REG_AW`: destination register.
- `issue_rs_i`, in, `NUM_SRC`*`REG_AW`: source registers; operand j occupies bits [j*`REG_AW` +: `REG_AW`].
- `flush_i`, in, 1: kill the issuing instruction.
- `stall_o`, out, 1: hold the fetch and ID stages; a bubble enters EX.
- `fwd_sel_o`, out, `NUM_SRC`*`SELW`: per-operand select. 0 = register file; k = result of entry k-1.
- `stall_cnt_o`, out, `CNT_W`: saturating count of stall cycles.

## Operation
- State is `DEPTH` entries, each holding {valid, regwrite, is_load, rd}.
- Entry k is live when valid=1, regwrite=1 and rd≠0.
- Shift, every rising edge:
  - entry[k] ← entry[k-1] for k ≥ 1.
  - entry[0] ← the issuing instruction if `issue_valid_i` & !`stall_o` & !`flush_i`; otherwise a bubble (all fields 0).
- Forwarding, per operand j with source s, combinational:
  - If s = 0, sel = 0.
  - Otherwise find the lowest k with a live entry[k] where rd = s. sel = k+1. If there is no match, sel = 0.
  - When several entries match, the youngest (lowest k) always wins.
- Load-use hazard:
  - Operand j hazards when its winning entry has is_load=1 and k < `LOAD_READY`.
  - `stall_o` = `issue_valid_i` & !`flush_i` & (any operand hazards).
  - When `stall_o`=1, `fwd_sel_o` is don't-care. The consumer ignores it.
- Stall rules:
  - Upstream holds all `issue_*` inputs stable while `stall_o`=1.
  - The stall releases automatically once the load shifts to entry ≥ `LOAD_READY`.
- Flush: `flush_i`=1 forces a bubble into entry 0 and forces `stall_o`=0. Older entries are unaffected.
- Counter: `stall_cnt_o` increments on each edge where `stall_o`=1. It saturates at all-ones and never wraps.
- An invalid issue (`issue_valid_i`=0) never stalls and is never recorded.

## Timing
- `fwd_sel_o` and `stall_o` are combinational, same cycle, from the registered entries and current inputs. There is no path from `issue_rd_i` to any output.
- State updates on the rising edge of `clk_i`.
- A producer issued at edge n is visible as sel=1 during cycle n+1, sel=2 during n+2, and so on. It ages out after `DEPTH` cycles.
- Load-use stall length = `LOAD_READY` − k for a load at entry k. With the defaults this is exactly 1 cycle for a back-to-back load-use.
- Reset (`rst_n_i`=0), asynchronous:
  - All entries clear immediately.
  - `stall_o`=0, `fwd_sel_o`=0 and `stall_cnt_o`=0 as soon as reset asserts.
  - Reset mid-stall drops the stall at once and discards in-flight tags.
- Deassertion takes effect at the next rising edge.

## Test plan
- Reset with entries populated: assert `rst_n_i`=0 mid-cycle → all entries, `stall_o`, `fwd_sel_o` and `stall_cnt_o` read 0 before the next edge.
- Issue ALU r3. Next cycle issue rs0=r3 → sel0=1. Issue rs1=r3 two cycles after the producer → sel1=2. Issue four cycles after the producer → sel=0.
- Issue load r5, then rs0=r5 → `stall_o`=1 for exactly one cycle, a bubble enters EX, then sel0=2 with `stall_o`=0, and `stall_cnt_o`=1.
- Issue ALU r7 back to back twice, then read r7 → sel=1 (youngest wins), never 2.
- A writer with rd=0, then a source of 0 → sel=0 and no stall. A load r9 followed by an issue with `flush_i`=1 reading r9 → `stall_o`=0 and entry 0 is a bubble.
- Force `CNT_W`=2 and run 5 consecutive stall cycles → `stall_cnt_o` holds 3.
